switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Multi-channel synchroniser and debouncer for the board's slide switches and push-button. Sits directly upstream of `shift_reg`: it turns raw, bouncing, asynchronous switch levels into clean synchronous levels plus single-cycle rise and fall pulses. Those outputs then drive the shift register's reset, write-enable and shift controls. Debounce time is counted in ticks of a slow clock-enable, either external or generated internally.

## Interface
- `N_CHANNELS`, default 8: number of independent input channels.
- `STABLE_TICKS`, default 4: consecutive ticks an input must hold a new value before it is accepted. Must be ≥ 1.
- `TICK_DIV`, default 4096: internal prescaler period in clocks. Used only with `DEBOUNCE_INTERNAL_TICK_EN`. Must be ≥ 2.
- `i_clk` input 1: system clock. All logic is on the rising edge.
- `i_reset_n` input 1: one clock; reset is asynchronous and active-low.
- `i_tick` input 1: one-cycle clock-enable that paces debounce counting. Ignored when `DEBOUNCE_INTERNAL_TICK_EN` is defined.
- `i_raw` input N_CHANNELS: raw asynchronous switch and button levels.
- `o_level` output N_CHANNELS: debounced level.
- `o_rise` output N_CHANNELS: one-cycle pulse when `o_level[k]` goes 0→1.
- `o_fall` output N_CHANNELS: one-cycle pulse when `o_level[k]` goes 1→0.
- `o_changed` output 1: OR of all `o_rise` and `o_fall` bits in the same cycle.

## Operation
- **Synchroniser:** each channel passes through a 2-FF synchroniser (`sync`). Its reset value is 0.
- **Per-channel FSM, state STABLE:**
  - Entered when `sync == o_level`; the counter is held at 0.
  - Leaves to CHANGING on the first cycle where `sync != o_level`.
- **Per-channel FSM, state CHANGING:**
  - On each cycle with a tick, the counter increments.
  - If `sync` returns to `o_level` in any cycle, the FSM goes to STABLE and the counter clears. This rejects bounce.
  - On the tick where the counter equals `STABLE_TICKS-1` while `sync` still differs:
    - `o_level` takes `sync`.
    - `o_rise` or `o_fall` pulses for exactly one cycle.
    - The counter clears and the FSM returns to STABLE.
- **Counter width:** `$clog2(STABLE_TICKS+1)`. The counter never wraps, because acceptance always clears it first.
- **Channel independence:**
  - Channels are fully independent.
  - Simultaneous changes on several channels produce pulses in the same cycle.
  - A rise on one channel and a fall on another in the same cycle are both reported.
- **Tick and change together:** a tick arriving in the same cycle that `sync` first differs counts as the first tick.
- **Pulse exclusivity:** `o_rise[k]` and `o_fall[k]` are never high together.

## Timing
- **Reset:** every output is 0. Synchronisers, counters, FSMs (in STABLE) and the prescaler are all 0.
- **Asynchronous clear mid-operation:** asserting reset mid-count clears everything immediately. No pulse is emitted.
- **After reset release:** an input held at 1 re-qualifies from scratch. It produces an `o_rise` after the full debounce time.
- **Latency, raw change to `sync`:** 2 clocks.
- **Latency, `sync` change to `o_level`:** the `STABLE_TICKS`-th tick sampled while `sync` stays continuously different. `o_level` updates on that clock edge.
- **Pulse alignment:** pulses are registered. They are aligned with the `o_level` update and last one clock.
- **`STABLE_TICKS=1`:** the first tick after divergence accepts the new value.

## Configuration
- **`DEBOUNCE_INTERNAL_TICK_EN` defined:**
  - An internal prescaler counts 0..`TICK_DIV-1` and emits a tick when it reaches `TICK_DIV-1`. The first tick occurs `TICK_DIV` clocks after reset release.
  - `i_tick` is unused.
- **`DEBOUNCE_INTERNAL_TICK_EN` undefined:**
  - There is no prescaler logic.
  - `i_tick` paces counting directly, so `top`'s existing counter-derived enable can be shared.

## Structure
- **Shared package `debounce_pkg`:**
  - FSM state enum: `ST_STABLE`, `ST_CHANGING`.
  - Default constants `DEBOUNCE_STABLE_TICKS_DEF = 4` and `DEBOUNCE_TICK_DIV_DEF = 4096`.
- **Sub-module `debounce_channel`:** one channel containing synchroniser, counter, FSM and pulse registers. It is instantiated `N_CHANNELS` times in a generate loop.
- **Top level:** holds the optional prescaler and the `o_changed` reduction.

## Test plan
All scenarios use `N_CHANNELS=8` and `STABLE_TICKS=4`. An external tick every 4 clocks is used unless stated.
1. **Reset:** `i_reset_n=0`, `i_raw=8'hFF` → `o_level`, `o_rise`, `o_fall` = 0 and `o_changed`=0 throughout reset.
2. **Clean press:** `i_raw[0]` 0→1 and held → `o_level[0]`=1 on the 4th tick after `sync` changes. `o_rise`=8'h01 for exactly one cycle and `o_changed`=1 in that cycle.
3. **Bounce:** `i_raw[1]` toggles every 3 clocks for 30 clocks, then holds 1 → no pulse during the bouncing. A single `o_rise`=8'h02 follows 4 ticks after the last toggle reaches `sync`.
4. **Simultaneous:** `i_raw[2]` and `i_raw[5]` rise in the same cycle, then later only bit 2 falls.
   - Same-cycle rise → `o_rise`=8'h24 in one cycle.
   - Later fall of bit 2 → `o_fall`=8'h04, `o_rise`=0.
5. **Reset mid-count:** after 3 qualifying ticks on `i_raw[3]`=1, pulse `i_reset_n` low → no pulse is emitted. After release, `o_rise[3]` requires 4 fresh ticks.
6. **`DEBOUNCE_INTERNAL_TICK_EN` with `TICK_DIV=8`, `i_tick` tied 1:** `i_raw[7]` rises → `o_rise[7]` occurs on the 4th internal tick, not sooner.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM states and
// default timing constants.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_e;

  localparam int DEBOUNCE_STABLE_TICKS_DEF = 4;
  localparam int DEBOUNCE_TICK_DIV_DEF     = 4096;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, tick counter, STABLE/CHANGING FSM
// and registered rise/fall pulses aligned with the accepted level.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync_p0;
  logic             sync_p1;
  deb_state_e       state_p2;
  deb_state_e       state_nxt;
  logic [CNT_W-1:0] cnt_p2;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_p2;
  logic             level_nxt;
  logic             rise_p2;
  logic             rise_nxt;
  logic             fall_p2;
  logic             fall_nxt;

  // Stage p0/p1: two-flop synchroniser for the asynchronous switch level
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= i_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: FSM state, qualification counter, accepted level and pulses
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_p2 <= ST_STABLE;
      cnt_p2   <= '0;
      level_p2 <= 1'b0;
      rise_p2  <= 1'b0;
      fall_p2  <= 1'b0;
    end else begin
      state_p2 <= state_nxt;
      cnt_p2   <= cnt_nxt;
      level_p2 <= level_nxt;
      rise_p2  <= rise_nxt;
      fall_p2  <= fall_nxt;
    end
  end

  // Next-state logic: a divergence seen in STABLE is handled exactly like
  // CHANGING (counter is 0 there), so a tick in the first differing cycle
  // counts as the first qualifying tick.
  always_comb begin
    state_nxt = state_p2;
    cnt_nxt   = cnt_p2;
    level_nxt = level_p2;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sync_p1 == level_p2) begin
      state_nxt = ST_STABLE;
      cnt_nxt   = '0;
    end else begin
      state_nxt = ST_CHANGING;
      if (state_p2 == ST_STABLE) cnt_nxt = '0;
      if (i_tick) begin
        if (((state_p2 == ST_STABLE) ? '0 : cnt_p2) == CNT_LAST) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
          level_nxt = sync_p1;
          rise_nxt  = sync_p1;
          fall_nxt  = ~sync_p1;
        end else begin
          cnt_nxt = ((state_p2 == ST_STABLE) ? '0 : cnt_p2) + 1'b1;
        end
      end
    end
  end

  assign o_level = level_p2;
  assign o_rise  = rise_p2;
  assign o_fall  = fall_p2;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch synchroniser/debouncer. Optional feature macro:
// DEBOUNCE_INTERNAL_TICK_EN selects an internal TICK_DIV prescaler as the
// debounce tick source instead of i_tick.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CHANNELS   = 8,
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEF,
  parameter int TICK_DIV     = DEBOUNCE_TICK_DIV_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_tick,
  input  logic [N_CHANNELS-1:0] i_raw,
  output logic [N_CHANNELS-1:0] o_level,
  output logic [N_CHANNELS-1:0] o_rise,
  output logic [N_CHANNELS-1:0] o_fall,
  output logic                  o_changed
);

  logic tick;

`ifdef DEBOUNCE_INTERNAL_TICK_EN
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc_p0;
  logic             unused_tick;

  assign unused_tick = i_tick;

  // Prescaler: free-running 0..TICK_DIV-1, tick while at the terminal count
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_p0 <= '0;
    end else if (presc_p0 == PRE_LAST) begin
      presc_p0 <= '0;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
    end
  end

  assign tick = (presc_p0 == PRE_LAST);
`else
  assign tick = i_tick;
`endif

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_tick    (tick),
      .i_raw     (i_raw[k]),
      .o_level   (o_level[k]),
      .o_rise    (o_rise[k]),
      .o_fall    (o_fall[k])
    );
  end

  assign o_changed = |(o_rise | o_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed testbench for switch_debouncer (N_CHANNELS=8, STABLE_TICKS=4).
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_tick = 1'b0;
  logic [7:0] i_raw = 8'hFF;
  logic [7:0] o_level;
  logic [7:0] o_rise;
  logic [7:0] o_fall;
  logic       o_changed;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] acc = '0;

  switch_debouncer #(
    .N_CHANNELS   (8),
    .STABLE_TICKS (4),
    .TICK_DIV     (8)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_tick    (i_tick),
    .i_raw     (i_raw),
    .o_level   (o_level),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_changed (o_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then set this cycle's tick.
  // Cycle c carries an external tick when c%4 == 0.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
`ifdef DEBOUNCE_INTERNAL_TICK_EN
    i_tick = 1'b1;
`else
    i_tick = (cyc % 4 == 0);
`endif
    acc = acc | o_rise | o_fall;
  endtask

  task automatic align();
    while (cyc % 4 != 1) step();
  endtask

  // Stimulus was applied in the current cycle; expect the pulse n clocks later.
  task automatic expect_pulse(input string tag, input int n, input logic [7:0] r, input logic [7:0] f);
    acc = '0;
    repeat (n - 1) step();
    check({tag, "_early"}, acc, 0);
    step();
    check({tag, "_rise"}, o_rise, r);
    check({tag, "_fall"}, o_fall, f);
    check({tag, "_chg"}, o_changed, ((r | f) != 0));
    step();
    check({tag, "_after"}, o_rise | o_fall, 0);
  endtask

  initial begin
    // Reset held with all inputs high: every output stays 0
    repeat (4) begin
      step();
      check("rst_level", o_level, 0);
      check("rst_pulse", o_rise | o_fall, 0);
      check("rst_chg", o_changed, 0);
    end

`ifdef DEBOUNCE_INTERNAL_TICK_EN
    // Internal prescaler, TICK_DIV=8, i_tick tied high: 4th tick at 32 clocks
    i_raw = 8'h00;
    repeat (3) step();
    i_raw = 8'h80;
    i_reset_n = 1'b1;
    expect_pulse("int_tick", 32, 8'h80, 8'h00);
    check("int_level", o_level, 8'h80);
`else
    i_raw = 8'h00;
    align();
    i_reset_n = 1'b1;
    repeat (8) step();
    check("idle_level", o_level, 0);

    // Clean press on channel 0
    align();
    i_raw[0] = 1'b1;
    expect_pulse("press", 16, 8'h01, 8'h00);
    check("press_level", o_level, 8'h01);

    // Channel 1 bounces every 3 clocks for 30 clocks, then holds high
    align();
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      i_raw[1] = ~i_raw[1];
      repeat (3) step();
    end
    check("bounce_quiet", acc, 0);
    check("bounce_level", o_level, 8'h01);
    i_raw[1] = 1'b1;
    expect_pulse("bounce", 18, 8'h02, 8'h00);
    check("bounce_level2", o_level, 8'h03);

    // Simultaneous rise on channels 2 and 5, then only channel 2 falls
    align();
    i_raw = i_raw | 8'h24;
    expect_pulse("simul", 16, 8'h24, 8'h00);
    check("simul_level", o_level, 8'h27);
    align();
    i_raw[2] = 1'b0;
    expect_pulse("fall2", 16, 8'h00, 8'h04);
    check("fall2_level", o_level, 8'h23);

    // Reset after 3 qualifying ticks on channel 3: no pulse, fresh qualify
    align();
    i_raw[3] = 1'b1;
    acc = '0;
    repeat (12) step();
    check("mid_quiet", acc, 0);
    check("mid_level", o_level, 8'h23);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_level", o_level, 0);
    check("mid_rst_pulse", o_rise | o_fall, 0);
    acc = '0;
    repeat (2) step();
    align();
    check("mid_rst_quiet", acc, 0);
    i_reset_n = 1'b1;
    expect_pulse("requal", 16, 8'h2B, 8'h00);
    check("requal_level", o_level, 8'h2B);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
